fft_4p_serial: RTL and testbench



---
 rtl/sat_pkg.sv | 54 +++++
 rtl/fft_bfly_r2.sv | 24 ++
 rtl/fft_4p_serial.sv | 165 ++++++++++++++++
 tb/tb_fft_4p_serial.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sat_pkg.sv
// Shared types and symmetric-saturation arithmetic for the 4-point FFT datapath.
// All complex words are 8-bit signed, held within [-127, 127].
package sat_pkg;

  localparam int FFT_N = 4;

  typedef struct packed {
    logic signed [7:0] re;
    logic signed [7:0] im;
  } cplx8_t;

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    ST1   = 2'd1,
    ST2   = 2'd2,
    DRAIN = 2'd3
  } fft_state_t;

  // Symmetric clamp: -128 is not a legal result, so it folds to -127.
  function automatic logic signed [7:0] sym_sat_9_8(input logic signed [8:0] v);
    if (v > 9'sd127) begin
      return 8'sd127;
    end else if (v < -9'sd127) begin
      return -8'sd127;
    end else begin
      return v[7:0];
    end
  endfunction

  function automatic cplx8_t cadd_sat(input cplx8_t a, input cplx8_t b, output logic sat);
    logic signed [8:0] wr;
    logic signed [8:0] wi;
    cplx8_t r;
    wr = {a.re[7], a.re} + {b.re[7], b.re};
    wi = {a.im[7], a.im} + {b.im[7], b.im};
    r.re = sym_sat_9_8(wr);
    r.im = sym_sat_9_8(wi);
    sat = (wr != {r.re[7], r.re}) || (wi != {r.im[7], r.im});
    return r;
  endfunction

  function automatic cplx8_t csub_sat(input cplx8_t a, input cplx8_t b, output logic sat);
    logic signed [8:0] wr;
    logic signed [8:0] wi;
    cplx8_t r;
    wr = {a.re[7], a.re} - {b.re[7], b.re};
    wi = {a.im[7], a.im} - {b.im[7], b.im};
    r.re = sym_sat_9_8(wr);
    r.im = sym_sat_9_8(wi);
    sat = (wr != {r.re[7], r.re}) || (wi != {r.im[7], r.im});
    return r;
  endfunction

endpackage

// File: rtl/fft_bfly_r2.sv
// Combinational radix-2 butterfly with symmetric saturation on both outputs.
// sat reports whether any of the four component results was clamped.
module fft_bfly_r2
  import sat_pkg::*;
(
  input  cplx8_t a,
  input  cplx8_t b,
  output cplx8_t sum,
  output cplx8_t diff,
  output logic   sat
);

  logic sat_sum;
  logic sat_diff;

  always_comb begin
    sat_sum  = 1'b0;
    sat_diff = 1'b0;
    sum      = cadd_sat(a, b, sat_sum);
    diff     = csub_sat(a, b, sat_diff);
    sat      = sat_sum || sat_diff;
  end

endmodule

// File: rtl/fft_4p_serial.sv
// Streaming 4-point complex FFT: buffer one frame, two registered butterfly
// stages, then drain four bins with valid/ready handshakes on both sides.
module fft_4p_serial
  import sat_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter bit BIT_REV_OUT = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_re,
  input  logic [DATA_W-1:0] in_im,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_re,
  output logic [DATA_W-1:0] out_im,
  output logic [1:0]        out_idx,
  output logic              out_last,
  output logic              out_sat
);

  if (DATA_W != 8) begin : g_bad_width
    $error("fft_4p_serial: DATA_W must be 8");
  end

  fft_state_t state_reg, state_next;
  logic [1:0] cnt_reg;
  logic [1:0] ocnt_reg;
  logic       in_ready_reg;
  logic       sat_reg;
  logic       in_fire;
  logic       out_fire;
  logic [1:0] sel;

  cplx8_t x_reg   [FFT_N];
  cplx8_t bin_reg [FFT_N];
  cplx8_t a_reg, b_reg, c_reg, d_reg;
  cplx8_t d_rot;

  cplx8_t     s1_sum  [2];
  cplx8_t     s1_diff [2];
  logic [1:0] s1_sat;
  cplx8_t     s2_a    [2];
  cplx8_t     s2_b    [2];
  cplx8_t     s2_sum  [2];
  cplx8_t     s2_diff [2];
  logic [1:0] s2_sat;

  // in_ready_reg is only ever high while in FILL, so it alone qualifies input transfers.
  assign in_fire  = in_valid && in_ready_reg;
  assign out_fire = (state_reg == DRAIN) && out_ready;

  // Stage 1 pairs x0/x2 and x1/x3; stage 2 pairs a/c and b/(-j*d).
  always_comb begin
    d_rot.re = d_reg.im;
    d_rot.im = -d_reg.re;
  end

  assign s2_a[0] = a_reg;
  assign s2_b[0] = c_reg;
  assign s2_a[1] = b_reg;
  assign s2_b[1] = d_rot;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_bfly
      fft_bfly_r2 u_st1 (
        .a    (x_reg[gi]),
        .b    (x_reg[gi+2]),
        .sum  (s1_sum[gi]),
        .diff (s1_diff[gi]),
        .sat  (s1_sat[gi])
      );
      fft_bfly_r2 u_st2 (
        .a    (s2_a[gi]),
        .b    (s2_b[gi]),
        .sum  (s2_sum[gi]),
        .diff (s2_diff[gi]),
        .sat  (s2_sat[gi])
      );
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= FILL;
      in_ready_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      in_ready_reg <= (state_next == FILL);
    end
  end

  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      FILL:    if (in_fire && cnt_reg == 2'(FFT_N - 1)) state_next = ST1;
      ST1:     state_next = ST2;
      ST2:     state_next = DRAIN;
      DRAIN:   if (out_fire && ocnt_reg == 2'(FFT_N - 1)) state_next = FILL;
      default: state_next = FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg  <= '0;
      ocnt_reg <= '0;
      sat_reg  <= 1'b0;
      a_reg    <= '0;
      b_reg    <= '0;
      c_reg    <= '0;
      d_reg    <= '0;
      for (int i = 0; i < FFT_N; i++) begin
        x_reg[i]   <= '0;
        bin_reg[i] <= '0;
      end
    end else begin
      if (in_fire) begin
        x_reg[cnt_reg] <= {in_re, in_im};
        cnt_reg        <= cnt_reg + 2'd1;
      end
      // Entering ST1 starts a fresh saturation record for the frame.
      if (state_reg == ST1) begin
        a_reg   <= s1_sum[0];
        b_reg   <= s1_diff[0];
        c_reg   <= s1_sum[1];
        d_reg   <= s1_diff[1];
        sat_reg <= |s1_sat;
      end
      if (state_reg == ST2) begin
        bin_reg[0] <= s2_sum[0];
        bin_reg[2] <= s2_diff[0];
        bin_reg[1] <= s2_sum[1];
        bin_reg[3] <= s2_diff[1];
        sat_reg    <= sat_reg || (|s2_sat);
      end
      if (out_fire) begin
        ocnt_reg <= ocnt_reg + 2'd1;
      end
    end
  end

  always_comb begin
    sel       = BIT_REV_OUT ? {ocnt_reg[0], ocnt_reg[1]} : ocnt_reg;
    in_ready  = in_ready_reg;
    out_valid = 1'b0;
    out_re    = '0;
    out_im    = '0;
    out_idx   = '0;
    out_last  = 1'b0;
    out_sat   = 1'b0;
    if (state_reg == DRAIN) begin
      out_valid = 1'b1;
      out_re    = bin_reg[sel].re;
      out_im    = bin_reg[sel].im;
      out_idx   = sel;
      out_last  = (ocnt_reg == 2'(FFT_N - 1));
      out_sat   = sat_reg;
    end
  end

endmodule

// File: tb/tb_fft_4p_serial.sv
// Directed bench for fft_4p_serial: natural-order and bit-reversed instances
// run in lock-step on the same stimulus, checked against hand-computed bins.
module tb_fft_4p_serial;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       out_ready;
  logic [7:0] in_re, in_im;

  logic       in_ready, out_valid, out_last, out_sat;
  logic [7:0] out_re, out_im;
  logic [1:0] out_idx;
  logic       br_in_ready, br_out_valid, br_out_last, br_out_sat;
  logic [7:0] br_out_re, br_out_im;
  logic [1:0] br_out_idx;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] g_re [4], g_im [4], gb_re [4], gb_im [4];
  logic [1:0] g_idx [4], gb_idx [4];
  logic       g_last [4], g_sat [4], g_rdy [4];
  logic [7:0] st_re [8], st_im [8];
  logic [1:0] st_idx [8];
  logic       st_valid [8], st_rdy [8];

  int br_ord [4] = '{0, 2, 1, 3};

  always #5 clk = ~clk;

  fft_4p_serial #(.DATA_W(8), .BIT_REV_OUT(1'b0)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_re(in_re), .in_im(in_im), .out_valid(out_valid), .out_ready(out_ready),
    .out_re(out_re), .out_im(out_im), .out_idx(out_idx), .out_last(out_last),
    .out_sat(out_sat)
  );

  fft_4p_serial #(.DATA_W(8), .BIT_REV_OUT(1'b1)) dut_br (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(br_in_ready),
    .in_re(in_re), .in_im(in_im), .out_valid(br_out_valid), .out_ready(out_ready),
    .out_re(br_out_re), .out_im(br_out_im), .out_idx(br_out_idx), .out_last(br_out_last),
    .out_sat(br_out_sat)
  );

  task automatic send_frame(input int re [4], input int im [4], input int max_gap);
    int t;
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b0;
      if (max_gap > 0) repeat ($urandom_range(max_gap, 0)) begin @(posedge clk); #1; end
      in_valid = 1'b1;
      in_re    = 8'(re[i]);
      in_im    = 8'(im[i]);
      t = 0;
      @(negedge clk);
      while (!in_ready && t < 50) begin @(negedge clk); t++; end
      if (!in_ready) begin
        n_cmp++; n_bad++;
        $display("FAIL in_ready_timeout sample%0d: in_ready=%0b want 1", i, in_ready);
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      $display("in  sample%0d re=%0d im=%0d", i, re[i], im[i]);
    end
  endtask

  task automatic collect(input int n, input int stall_at, input int stall_len);
    int t;
    @(posedge clk); #1;
    for (int i = 0; i < n; i++) begin
      if (i == stall_at) begin
        out_ready = 1'b0;
        for (int s = 0; s < stall_len; s++) begin
          @(negedge clk);
          st_valid[s] = out_valid; st_rdy[s] = in_ready;
          st_re[s] = out_re; st_im[s] = out_im; st_idx[s] = out_idx;
        end
        @(posedge clk); #1;
      end
      out_ready = 1'b1;
      t = 0;
      @(negedge clk);
      while (!out_valid && t < 50) begin @(negedge clk); t++; end
      if (!out_valid) begin
        n_cmp++; n_bad++;
        $display("FAIL out_valid_timeout bin%0d: out_valid=%0b want 1", i, out_valid);
      end
      g_re[i] = out_re; g_im[i] = out_im; g_idx[i] = out_idx;
      g_last[i] = out_last; g_sat[i] = out_sat; g_rdy[i] = in_ready;
      gb_re[i] = br_out_re; gb_im[i] = br_out_im; gb_idx[i] = br_out_idx;
      $display("out bin k=%0d re=%0d im=%0d last=%0b sat=%0b | br k=%0d re=%0d im=%0d",
               out_idx, $signed(out_re), $signed(out_im), out_last, out_sat,
               br_out_idx, $signed(br_out_re), $signed(br_out_im));
      @(posedge clk); #1;
    end
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_re = '0; in_im = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if ({in_ready, br_in_ready} !== 2'b00) begin
      n_bad++; $display("FAIL reset_in_ready: got %0b/%0b want 0/0", in_ready, br_in_ready);
    end
    n_cmp++;
    if ({out_valid, br_out_valid} !== 2'b00) begin
      n_bad++; $display("FAIL reset_out_valid: got %0b/%0b want 0/0", out_valid, br_out_valid);
    end
    n_cmp++;
    if ({out_re, out_im} !== 16'h0000) begin
      n_bad++; $display("FAIL reset_data: got re=%0d im=%0d want 0 0", out_re, out_im);
    end
    n_cmp++;
    if ({out_idx, out_last, out_sat} !== 4'b0000) begin
      n_bad++; $display("FAIL reset_flags: got idx=%0d last=%0b sat=%0b want 0", out_idx, out_last, out_sat);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (in_ready !== 1'b0) begin
      n_bad++; $display("FAIL reset_release_early: in_ready=%0b want 0", in_ready);
    end
    @(negedge clk);
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_bad++; $display("FAIL reset_release_ready: in_ready=%0b want 1", in_ready);
    end
  endtask

  task automatic test_impulse();
    int x_re [4] = '{64, 0, 0, 0};
    int x_im [4] = '{0, 0, 0, 0};
    int e_re [4] = '{64, 64, 64, 64};
    int e_im [4] = '{0, 0, 0, 0};
    send_frame(x_re, x_im, 0);
    @(negedge clk);
    n_cmp++;
    if ({out_valid, in_ready} !== 2'b00) begin
      n_bad++; $display("FAIL latency_k: out_valid=%0b in_ready=%0b want 0 0", out_valid, in_ready);
    end
    @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_bad++; $display("FAIL latency_k1: out_valid=%0b want 0", out_valid);
    end
    @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b1) begin
      n_bad++; $display("FAIL latency_k2: out_valid=%0b want 1", out_valid);
    end
    collect(4, -1, 0);
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if ({g_re[i], g_im[i], g_idx[i], g_last[i], g_sat[i]} !==
          {8'(e_re[i]), 8'(e_im[i]), 2'(i), (i == 3), 1'b0}) begin
        n_bad++;
        $display("FAIL impulse bin%0d: got re=%0d im=%0d idx=%0d last=%0b sat=%0b want re=%0d im=%0d idx=%0d last=%0b sat=0",
                 i, $signed(g_re[i]), $signed(g_im[i]), g_idx[i], g_last[i], g_sat[i], e_re[i], e_im[i], i, (i == 3));
      end
      n_cmp++;
      if ({gb_re[i], gb_im[i], gb_idx[i]} !== {8'(e_re[br_ord[i]]), 8'(e_im[br_ord[i]]), 2'(br_ord[i])}) begin
        n_bad++;
        $display("FAIL impulse_br pos%0d: got re=%0d im=%0d idx=%0d want re=%0d im=%0d idx=%0d",
                 i, $signed(gb_re[i]), $signed(gb_im[i]), gb_idx[i], e_re[br_ord[i]], e_im[br_ord[i]], br_ord[i]);
      end
    end
  endtask

  task automatic run_frame_check(input string name, input int x_re [4], input int x_im [4],
                                 input int e_re [4], input int e_im [4], input logic e_sat);
    send_frame(x_re, x_im, 0);
    collect(4, -1, 0);
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if ({g_re[i], g_im[i], g_idx[i], g_last[i], g_sat[i]} !==
          {8'(e_re[i]), 8'(e_im[i]), 2'(i), (i == 3), e_sat}) begin
        n_bad++;
        $display("FAIL %s bin%0d: got re=%0d im=%0d idx=%0d last=%0b sat=%0b want re=%0d im=%0d idx=%0d last=%0b sat=%0b",
                 name, i, $signed(g_re[i]), $signed(g_im[i]), g_idx[i], g_last[i], g_sat[i],
                 e_re[i], e_im[i], i, (i == 3), e_sat);
      end
      n_cmp++;
      if ({gb_re[i], gb_im[i], gb_idx[i]} !== {8'(e_re[br_ord[i]]), 8'(e_im[br_ord[i]]), 2'(br_ord[i])}) begin
        n_bad++;
        $display("FAIL %s_br pos%0d: got re=%0d im=%0d idx=%0d want re=%0d im=%0d idx=%0d",
                 name, i, $signed(gb_re[i]), $signed(gb_im[i]), gb_idx[i], e_re[br_ord[i]], e_im[br_ord[i]], br_ord[i]);
      end
    end
  endtask

  task automatic test_dc_overflow();
    run_frame_check("dc_overflow", '{100, 100, 100, 100}, '{0, 0, 0, 0},
                    '{127, 0, 0, 0}, '{0, 0, 0, 0}, 1'b1);
  endtask

  task automatic test_asym_min();
    run_frame_check("asym_min", '{-128, 0, 0, 0}, '{0, 0, 0, 0},
                    '{-127, -127, -127, -127}, '{0, 0, 0, 0}, 1'b1);
  endtask

  task automatic test_rotation();
    run_frame_check("rotation", '{10, 0, 0, 0}, '{0, 10, 0, 0},
                    '{10, 20, 10, 0}, '{10, 0, -10, 0}, 1'b0);
  endtask

  task automatic test_back_to_back();
    int f1_re [4] = '{1, 3, 5, 7};
    int f1_im [4] = '{2, 4, 6, 8};
    int e1_re [4] = '{16, -8, -4, 0};
    int e1_im [4] = '{20, 0, -4, -8};
    int f2_re [4] = '{0, 0, 0, -5};
    int f2_im [4] = '{0, 0, 0, 3};
    int e2_re [4] = '{-5, -3, 5, 3};
    int e2_im [4] = '{3, -5, -3, 5};
    send_frame(f1_re, f1_im, 3);
    collect(4, 2, 5);
    for (int s = 0; s < 5; s++) begin
      n_cmp++;
      if ({st_valid[s], st_rdy[s], st_re[s], st_im[s], st_idx[s]} !== {1'b1, 1'b0, 8'(-4), 8'(-4), 2'd2}) begin
        n_bad++;
        $display("FAIL stall cyc%0d: got valid=%0b in_ready=%0b re=%0d im=%0d idx=%0d want 1 0 -4 -4 2",
                 s, st_valid[s], st_rdy[s], $signed(st_re[s]), $signed(st_im[s]), st_idx[s]);
      end
    end
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if ({g_re[i], g_im[i], g_idx[i], g_last[i], g_rdy[i]} !== {8'(e1_re[i]), 8'(e1_im[i]), 2'(i), (i == 3), 1'b0}) begin
        n_bad++;
        $display("FAIL gap_frame bin%0d: got re=%0d im=%0d idx=%0d last=%0b in_ready=%0b want re=%0d im=%0d idx=%0d last=%0b in_ready=0",
                 i, $signed(g_re[i]), $signed(g_im[i]), g_idx[i], g_last[i], g_rdy[i], e1_re[i], e1_im[i], i, (i == 3));
      end
    end
    @(negedge clk);
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_bad++; $display("FAIL ready_after_last: in_ready=%0b want 1", in_ready);
    end
    send_frame(f2_re, f2_im, 2);
    collect(4, -1, 0);
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if ({g_re[i], g_im[i], g_idx[i], g_sat[i]} !== {8'(e2_re[i]), 8'(e2_im[i]), 2'(i), 1'b0}) begin
        n_bad++;
        $display("FAIL b2b_frame bin%0d: got re=%0d im=%0d idx=%0d sat=%0b want re=%0d im=%0d idx=%0d sat=0",
                 i, $signed(g_re[i]), $signed(g_im[i]), g_idx[i], g_sat[i], e2_re[i], e2_im[i], i);
      end
    end
  endtask

  task automatic test_reset_mid_drain();
    int r_re [4] = '{10, 0, 0, 0};
    int r_im [4] = '{0, 10, 0, 0};
    int i_re [4] = '{64, 0, 0, 0};
    int i_im [4] = '{0, 0, 0, 0};
    send_frame(r_re, r_im, 0);
    collect(2, -1, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({out_valid, br_out_valid, in_ready} !== 3'b000) begin
      n_bad++; $display("FAIL mid_reset_next: out_valid=%0b br=%0b in_ready=%0b want 0 0 0", out_valid, br_out_valid, in_ready);
    end
    @(negedge clk);
    n_cmp++;
    if ({in_ready, out_valid} !== 2'b10) begin
      n_bad++; $display("FAIL mid_reset_after: in_ready=%0b out_valid=%0b want 1 0", in_ready, out_valid);
    end
    send_frame(i_re, i_im, 0);
    collect(4, -1, 0);
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if ({g_re[i], g_im[i], g_idx[i], g_last[i], g_sat[i]} !== {8'd64, 8'd0, 2'(i), (i == 3), 1'b0}) begin
        n_bad++;
        $display("FAIL post_reset bin%0d: got re=%0d im=%0d idx=%0d last=%0b sat=%0b want re=64 im=0 idx=%0d last=%0b sat=0",
                 i, $signed(g_re[i]), $signed(g_im[i]), g_idx[i], g_last[i], g_sat[i], i, (i == 3));
      end
    end
  endtask

  initial begin
    test_reset();
    test_impulse();
    test_dc_overflow();
    test_asym_min();
    test_rotation();
    test_back_to_back();
    test_reset_mid_drain();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time %0t exceeded bound, want completion", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
